// File: rtl/multibyte_add_seq.sv
// Multi-byte add sequencer: stages wide operands one byte at a time, LSB first, through an
// external 8-bit combinational adder. Define MULTIBYTE_ADD_SEQ_SUB_EN to add the in_sub port.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_cin,
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  input  logic                in_sub,
`endif
  output logic [7:0]          add_x,
  output logic [7:0]          add_y,
  output logic                add_c0,
  input  logic [7:0]          add_sum,
  input  logic                add_c8,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] res_sum,
  output logic                res_cout,
  output logic                res_ovf
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NBYTES - 1);
  localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    res_sum_q, res_sum_d;
  logic            res_cout_q, res_cout_d;
  logic            res_ovf_q, res_ovf_d;

  logic        sub_in;
  logic [7:0]  b_byte;
  logic        b_msb_eff;
  int unsigned byte_base;

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  assign sub_in = in_sub;
`else
  assign sub_in = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sub_d      = sub_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_ovf_d  = res_ovf_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_x      = 8'h00;
    add_y      = 8'h00;
    add_c0     = 1'b0;
    byte_base  = 32'(idx_q) * 8;
    b_byte     = sub_q ? ~b_q[byte_base +: 8] : b_q[byte_base +: 8];
    // Overflow is judged against the operand actually fed to the adder.
    b_msb_eff  = b_q[W-1] ^ sub_q;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = sub_in;
          carry_d = sub_in ? 1'b1 : in_cin;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        add_x  = a_q[byte_base +: 8];
        add_y  = b_byte;
        add_c0 = carry_q;
        if (cnt_q == SettleCnt) begin
          res_sum_d[byte_base +: 8] = add_sum;
          carry_d = add_c8;
          cnt_d   = '0;
          if (idx_q == LastIdx) begin
            res_cout_d = add_c8;
            res_ovf_d  = (a_q[W-1] == b_msb_eff) && (add_sum[7] != a_q[W-1]);
            state_d    = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sub_q      <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sub_q      <= sub_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign res_sum  = res_sum_q;
  assign res_cout = res_cout_q;
  assign res_ovf  = res_ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq with an ideal combinational adder; results are checked against a
// whole-word arithmetic model.
module tb_multibyte_add_seq;

  localparam int NB  = 4;
  localparam int ST  = 1;
  localparam int W   = 8 * NB;
  localparam int LAT = 1 + NB * (ST + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         in_sub;
  logic [7:0]   add_x, add_y, add_sum;
  logic         add_c0, add_c8;
  logic         out_valid, out_ready;
  logic [W-1:0] res_sum;
  logic         res_cout, res_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_c8, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'h00, add_c0};

  multibyte_add_seq #(.NBYTES(NB), .SETTLE(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .add_x     (add_x),
    .add_y     (add_y),
    .add_c0    (add_c0),
    .add_sum   (add_sum),
    .add_c8    (add_c8),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf)
  );

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic c,
                       output logic o);
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    s  = t[W-1:0];
    c  = t[W];
    o  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair from IDLE, waits for the result and completes the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W-1:0] s, output logic c,
                        output logic o, output int lat, output logic [7:0] x0);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    x0  = add_x;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL run_op_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    s = res_sum; c = res_cout; o = res_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, add_x, add_y, add_c0} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%0b vld=%0b x=%h y=%h c0=%0b, required 1 0 00 00 0",
               in_ready, out_valid, add_x, add_y, add_c0);
    end
    checks++;
    if ({res_sum, res_cout, res_ovf} !== {{W{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_res: sum=%h cout=%0b ovf=%0b, required 0 0 0",
               res_sum, res_cout, res_ovf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000,
                            32'hA5C3_1E0F};
    logic [W-1:0] vb[6] = '{32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0000_0001, 32'h8000_0000,
                            32'h5A3C_E1F0};
    logic         vc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] s, es;
    logic         c, o, ec, eo;
    logic [7:0]   x0;
    int           lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, s, c, o, lat, x0);
      model(va[i], vb[i], vc[i], 1'b0, es, ec, eo);
      checks++;
      if ({s, c, o} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL directed_%0d: sum=%h cout=%0b ovf=%0b, required %h %0b %0b",
                 i, s, c, o, es, ec, eo);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL directed_latency_%0d: %0d cycles, required %0d", i, lat, LAT);
      end
      checks++;
      if (x0 !== va[i][7:0]) begin
        errors++;
        $display("FAIL directed_first_byte_%0d: add_x=%h, required %h", i, x0, va[i][7:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2, es, s;
    logic         ec, eo, c, o;
    logic [7:0]   x0;
    int           n;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    in_a = a1; in_b = b1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_a = a2; in_b = b2;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    model(a1, b1, 1'b0, 1'b0, es, ec, eo);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_valid, in_ready, res_sum, res_cout, res_ovf} !== {2'b10, es, ec, eo}) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: vld=%0b rdy=%0b sum=%h c=%0b o=%0b, req 1 0 %h %0b %0b",
                 k, out_valid, in_ready, res_sum, res_cout, res_ovf, es, ec, eo);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    end
    run_op(a2, b2, 1'b0, 1'b0, s, c, o, n, x0);
    model(a2, b2, 1'b0, 1'b0, es, ec, eo);
    checks++;
    if ({s, c, o} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL backpressure_second: sum=%h c=%0b o=%0b, required %h %0b %0b",
               s, c, o, es, ec, eo);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s, es;
    logic         c, o, ec, eo;
    logic [7:0]   x0;
    int           lat;
    in_a = 32'hC3C3_A5A5; in_b = 32'h0101_1111; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, add_x, add_y, add_c0} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_ctrl: rdy=%0b vld=%0b x=%h y=%h c0=%0b, required 1 0 00 00 0",
               in_ready, out_valid, add_x, add_y, add_c0);
    end
    checks++;
    if ({res_sum, res_cout, res_ovf} !== {{W{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_res: sum=%h c=%0b o=%0b, required 0 0 0", res_sum, res_cout, res_ovf);
    end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s, c, o, lat, x0);
    model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, es, ec, eo);
    checks++;
    if ({s, c, o} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL reset_mid_after: sum=%h c=%0b o=%0b, required %h %0b %0b", s, c, o, es, ec, eo);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, s, es;
    logic         cin, sub, c, o, ec, eo;
    logic [7:0]   x0;
    int           lat;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom);
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      run_op(a, b, cin, sub, s, c, o, lat, x0);
      model(a, b, cin, sub, es, ec, eo);
      checks++;
      if ({s, c, o, lat} !== {es, ec, eo, LAT}) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h cin=%0b sub=%0b sum=%h c=%0b o=%0b lat=%0d, req %h %0b %0b %0d",
                 i, a, b, cin, sub, s, c, o, lat, es, ec, eo, LAT);
      end
    end
  endtask

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s;
    logic         c, o;
    logic [7:0]   x0;
    int           lat;
    run_op(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat, x0);
    checks++;
    if ({s, c, o} !== {32'hFFFF_FFFE, 2'b00}) begin
      errors++;
      $display("FAIL sub_5_7: sum=%h c=%0b o=%0b, required fffffffe 0 0", s, c, o);
    end
    run_op(32'd7, 32'd5, 1'b0, 1'b1, s, c, o, lat, x0);
    checks++;
    if ({s, c} !== {32'h0000_0002, 1'b1}) begin
      errors++;
      $display("FAIL sub_7_5: sum=%h c=%0b, required 00000002 1", s, c);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequential operand stager and result collector wrapped around the 8-bit conditional sum adder.
- Accepts wide operands over a valid/ready handshake and drives the adder one byte per step, least significant byte first.
- Chains the adder's c8 back into c0 for the next byte, assembles the wide sum, and presents it downstream over valid/ready.
- Adder core stays purely combinational; this block owns all sequencing.

Parameters:
- NBYTES, 4, operand width in bytes (>=1).
- SETTLE, 1, extra cycles each byte is held on the adder before capture (>=0).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  8*NBYTES  operand A.
- in_b  input  8*NBYTES  operand B.
- in_cin  input  1  carry-in to byte 0.
- add_x  output  8  to adder x.
- add_y  output  8  to adder y.
- add_c0  output  1  to adder c0.
- add_sum  input  8  from adder sum.
- add_c8  input  1  from adder c8.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- res_sum  output  8*NBYTES  assembled sum.
- res_cout  output  1  carry out of MSB byte.
- res_ovf  output  1  signed overflow.

Behaviour:
- Clocking and reset: one clock domain; rst sampled on the rising clk edge.
- Reset values: state IDLE; in_ready=1; out_valid=0; res_sum=0, res_cout=0, res_ovf=0; add_x=0, add_y=0, add_c0=0; all internal counters and carry register cleared.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1 and add_* driven to 0.
  - On in_valid&in_ready: register in_a, in_b, and in_cin (into carry_reg); set idx=0, cnt=0; go to ADD.
  - Registered operands make later upstream changes irrelevant.
- ADD:
  - in_ready=0.
  - add_x = a_reg byte[idx], add_y = b_reg byte[idx], add_c0 = carry_reg.
  - cnt increments each cycle.
  - When cnt==SETTLE: res_sum byte[idx] <= add_sum; carry_reg <= add_c8; cnt <= 0.
  - If idx==NBYTES-1: res_cout <= add_c8; res_ovf <= (a_msb==b_msb) && (add_sum[7]!=a_msb); go to DONE.
  - Otherwise idx++.
- Timing: each byte occupies SETTLE+1 cycles.
- Latency: if accept happens in cycle T, out_valid first goes high in cycle T+1+NBYTES*(SETTLE+1). With defaults this is T+9.
- DONE:
  - out_valid=1, in_ready=0.
  - res_* held stable until out_valid&out_ready; then go to IDLE and drop out_valid.
  - in_ready returns the cycle after the handshake.
  - res_* keep their last value after leaving DONE.
- in_valid while busy is ignored. No queuing; upstream must hold in_valid.
- Reset mid-operation: the in-flight operation is discarded and all outputs take reset values the next cycle.
- SETTLE=0: each byte captured in the same cycle it is driven (1 cycle/byte).

Optional Feature:
- Macro: MULTIBYTE_ADD_SEQ_SUB_EN.
- Defined:
  - Adds port in_sub (input, 1), registered at accept.
  - When set: add_y = ~b_reg byte[idx], and carry_reg initialised to 1 (in_cin ignored). Result is A-B.
  - res_cout=1 means no borrow; res_ovf is computed with inverted B's MSB.
- Undefined: port absent; add only.

Test Plan:
(NBYTES=4, SETTLE=1, ideal combinational adder model)
- a=0x000000FF, b=0x00000001, cin=0 -> res_sum=0x00000100, cout=0, ovf=0; out_valid exactly at T+9.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> res_sum=0x00000000, cout=1, ovf=0 (carry through all 4 bytes). Then a=0, b=0, cin=1 -> res_sum=0x00000001.
- a=0x7FFFFFFF, b=0x00000001 -> res_sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> res_sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands present.
  - out_valid and res_* stay stable; in_ready=0.
  - New operands are accepted only after out_ready pulses; their result is correct.
- rst asserted for 1 cycle while idx=2:
  - Next cycle: IDLE, in_ready=1, out_valid=0, add_*=0, res_*=0.
  - Subsequent a=0x12345678, b=0x11111111 -> res_sum=0x23456789.
- With MULTIBYTE_ADD_SEQ_SUB_EN: a=5, b=7, sub=1 -> res_sum=0xFFFFFFFE, cout=0, ovf=0. Also a=7, b=5 -> res_sum=0x00000002, cout=1.
